// File: rtl/rvfi_trace_buffer.sv
// rvfi_trace_buffer: compacts up to NRET RVFI retirements per cycle into one
// FIFO in channel order and drains one record per cycle over valid/ready.
// rvfi_order continuity is checked on admitted records; drops and order
// breaks are reported through sticky flags.
// Optional macro RVFI_TRACE_TIMESTAMP_EN adds a per-entry 32-bit push-cycle
// timestamp presented on trace_ts_o.
module rvfi_trace_buffer #(
  parameter int NRET    = 2,
  parameter int REC_W   = 160,
  parameter int DEPTH   = 16,
  parameter int ORDER_W = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NRET-1:0]           rvfi_valid_i,
  input  logic [NRET*ORDER_W-1:0]   rvfi_order_i,
  input  logic [NRET*REC_W-1:0]     rvfi_rec_i,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output logic [ORDER_W-1:0]        trace_order_o,
  output logic [REC_W-1:0]          trace_rec_o,
`ifdef RVFI_TRACE_TIMESTAMP_EN
  output logic [31:0]               trace_ts_o,
`endif
  output logic [$clog2(DEPTH):0]    level_o,
  output logic [15:0]               drop_cnt_o,
  output logic                      overflow_o,
  output logic                      order_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      wr_ptr, rd_ptr, level;
  logic [ORDER_W-1:0] order_mem [DEPTH];
  logic [REC_W-1:0]   rec_mem   [DEPTH];
  logic [ORDER_W-1:0] exp_q, exp_d;
  logic               err_d;
  logic [PW:0]        n, free;
  logic               pop, accept, drop;
  logic [AW-1:0]      slot [NRET];

  // Pointers carry an extra wrap bit, so the difference is the occupancy.
  assign level         = wr_ptr - rd_ptr;
  assign level_o       = level;
  assign trace_valid_o = (wr_ptr != rd_ptr);
  assign pop           = trace_valid_o && trace_ready_i;

  // Count valid channels and give each one a gap-free slot after wr_ptr.
  always_comb begin
    n = '0;
    for (int k = 0; k < NRET; k++) begin
      slot[k] = wr_ptr[AW-1:0] + n[AW-1:0];
      n       = n + (PW+1)'(rvfi_valid_i[k]);
    end
  end

  // A same-cycle pop frees a slot; admission is all-or-nothing.
  assign free   = (PW+1)'(DEPTH) - (PW+1)'(level) + (PW+1)'(pop);
  assign accept = (n != '0) && (n <= free);
  assign drop   = (n != '0) && !accept;

  // Walk admitted records in channel order; expected order chains through.
  always_comb begin
    exp_d = exp_q;
    err_d = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      if (accept && rvfi_valid_i[k]) begin
        if (rvfi_order_i[k*ORDER_W +: ORDER_W] != exp_d) err_d = 1'b1;
        exp_d = rvfi_order_i[k*ORDER_W +: ORDER_W] + ORDER_W'(1);
      end
    end
  end

  // Pointers, order tracking and sticky status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      exp_q       <= '0;
      order_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + n[PW-1:0];
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      exp_q       <= exp_d;
      order_err_o <= order_err_o | err_d;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NRET; k++) begin
      if (accept && rvfi_valid_i[k]) begin
        order_mem[slot[k]] <= rvfi_order_i[k*ORDER_W +: ORDER_W];
        rec_mem[slot[k]]   <= rvfi_rec_i[k*REC_W +: REC_W];
      end
    end
  end

  // Head is read straight from the storage flops; zeroed while empty.
  assign trace_order_o = trace_valid_o ? order_mem[rd_ptr[AW-1:0]] : '0;
  assign trace_rec_o   = trace_valid_o ? rec_mem[rd_ptr[AW-1:0]]   : '0;

`ifdef RVFI_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem [DEPTH];

  // Free-running cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end

  // Every record admitted in one cycle shares that cycle's timestamp.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NRET; k++) begin
      if (accept && rvfi_valid_i[k]) ts_mem[slot[k]] <= ts_q;
    end
  end

  assign trace_ts_o = trace_valid_o ? ts_mem[rd_ptr[AW-1:0]] : '0;
`endif
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench for rvfi_trace_buffer with a queue-based reference model.
module tb_rvfi_trace_buffer;
  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [1:0]   valid = '0;
  logic [127:0] order_in = '0;
  logic [319:0] rec_in = '0;
  logic         ready = 1'b0;
  logic         trace_valid_o;
  logic [63:0]  trace_order_o;
  logic [159:0] trace_rec_o;
  logic [4:0]   level_o;
  logic [15:0]  drop_cnt_o;
  logic         overflow_o, order_err_o;

  // Narrow-order instance used to exercise the order wrap.
  logic [1:0]  s_valid = '0;
  logic [5:0]  s_order = '0;
  logic [15:0] s_rec = '0;
  logic        s_tvalid, s_ovf, s_err;
  logic [2:0]  s_torder;
  logic [7:0]  s_trec;
  logic [3:0]  s_level;
  logic [15:0] s_drop;

  always #5 clk_i = ~clk_i;

  rvfi_trace_buffer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rvfi_valid_i(valid), .rvfi_order_i(order_in),
    .rvfi_rec_i(rec_in), .trace_valid_o(trace_valid_o), .trace_ready_i(ready),
    .trace_order_o(trace_order_o), .trace_rec_o(trace_rec_o), .level_o(level_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .order_err_o(order_err_o));

  rvfi_trace_buffer #(.NRET(2), .REC_W(8), .DEPTH(8), .ORDER_W(3)) dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .rvfi_valid_i(s_valid), .rvfi_order_i(s_order),
    .rvfi_rec_i(s_rec), .trace_valid_o(s_tvalid), .trace_ready_i(1'b1),
    .trace_order_o(s_torder), .trace_rec_o(s_trec), .level_o(s_level),
    .drop_cnt_o(s_drop), .overflow_o(s_ovf), .order_err_o(s_err));

  typedef struct { logic [63:0] o; logic [159:0] r; } ent_t;
  ent_t        q[$];
  int          m_drop;
  bit          m_ovf, m_err;
  logic [63:0] m_exp;
  int          tests = 0, fails = 0;
  bit          chk_en = 1'b0;

  function automatic logic [159:0] mkrec(logic [63:0] o, int k);
    return {~o, 32'hC0DE_0000 + k, o};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_drop = 0; m_ovf = 0; m_err = 0; m_exp = '0;
  endtask

  // One clock: drive at negedge, advance the model, return at posedge+3.
  task automatic cyc(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                     input logic rdy);
    int n, free;
    bit pop;
    logic [63:0] o;
    ent_t e;
    @(negedge clk_i);
    valid = v; order_in = {o1, o0}; rec_in = {mkrec(o1, 1), mkrec(o0, 0)}; ready = rdy;
    n    = int'(v[0]) + int'(v[1]);
    pop  = rdy && (q.size() != 0);
    free = 16 - q.size() + int'(pop);
    if (pop) void'(q.pop_front());
    if (n > 0) begin
      if (n <= free) begin
        for (int k = 0; k < 2; k++) begin
          if (v[k]) begin
            o = (k == 0) ? o0 : o1;
            if (o != m_exp) m_err = 1;
            m_exp = o + 64'd1;
            e.o = o; e.r = mkrec(o, k);
            q.push_back(e);
          end
        end
      end else begin
        m_ovf = 1;
        if (m_drop < 16'hFFFF) m_drop++;
      end
    end
    @(posedge clk_i); #3;
  endtask

  task automatic scyc(input logic [1:0] v, input logic [2:0] o0, input logic [2:0] o1);
    @(negedge clk_i);
    s_valid = v; s_order = {o1, o0}; s_rec = {5'd0, o1, 5'd0, o0};
    @(posedge clk_i); #3;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0; valid = '0; ready = 1'b0; s_valid = '0;
    model_clear();
    @(negedge clk_i);
    rst_ni = 1'b1; chk_en = 1'b1;
  endtask

  // Every-cycle comparison of the main DUT against the model.
  always begin
    @(posedge clk_i); #3;
    if (chk_en) begin
      check("cmp valid", 160'(trace_valid_o), 160'(q.size() != 0));
      if (q.size() != 0) begin
        check("cmp order", 160'(trace_order_o), 160'(q[0].o));
        check("cmp rec", trace_rec_o, q[0].r);
      end
      check("cmp level", 160'(level_o), 160'(q.size()));
      check("cmp drop", 160'(drop_cnt_o), 160'(m_drop));
      check("cmp ovf", 160'(overflow_o), 160'(m_ovf));
      check("cmp err", 160'(order_err_o), 160'(m_err));
    end
  end

  initial begin
    model_clear();
    #12;
    check("rst valid", 160'(trace_valid_o), 160'(0));
    check("rst level", 160'(level_o), 160'(0));
    check("rst drop", 160'(drop_cnt_o), 160'(0));
    check("rst flags", 160'({overflow_o, order_err_o}), 160'(0));
    check("rst order", 160'(trace_order_o), 160'(0));
    check("rst rec", trace_rec_o, 160'(0));
    @(negedge clk_i); rst_ni = 1'b1; chk_en = 1'b1;

    // Single push, one-cycle latency, then pop.
    cyc(2'b01, 64'd0, 64'd0, 1'b0);
    check("t1 valid", 160'(trace_valid_o), 160'(1));
    check("t1 order", 160'(trace_order_o), 160'(0));
    check("t1 level", 160'(level_o), 160'(1));
    cyc(2'b00, 64'd0, 64'd0, 1'b1);
    check("t1 level pop", 160'(level_o), 160'(0));
    check("t1 err", 160'(order_err_o), 160'(0));

    // Compaction of channel 1 alone, then both channels.
    do_reset();
    cyc(2'b10, 64'hBAD, 64'd0, 1'b0);
    check("t2 rec", trace_rec_o, {~64'd0, 32'hC0DE_0001, 64'd0});
    cyc(2'b11, 64'd1, 64'd2, 1'b0);
    check("t2 level", 160'(level_o), 160'(3));
    for (int i = 0; i < 3; i++) cyc(2'b00, 64'd0, 64'd0, 1'b1);
    check("t2 level end", 160'(level_o), 160'(0));
    check("t2 err", 160'(order_err_o), 160'(0));

    // Overflow with consumer stalled.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(2'b11, 64'(2*i), 64'(2*i+1), 1'b0);
    cyc(2'b01, 64'd14, 64'd0, 1'b0);
    check("t3 level15", 160'(level_o), 160'(15));
    cyc(2'b11, 64'd15, 64'd16, 1'b0);
    check("t3 level drop", 160'(level_o), 160'(15));
    check("t3 ovf", 160'(overflow_o), 160'(1));
    check("t3 drop", 160'(drop_cnt_o), 160'(1));
    check("t3 err pre", 160'(order_err_o), 160'(0));
    cyc(2'b01, 64'd17, 64'd0, 1'b0);
    check("t3 err", 160'(order_err_o), 160'(1));
    check("t3 full", 160'(level_o), 160'(16));

    // Full with simultaneous pop.
    cyc(2'b01, 64'd18, 64'd0, 1'b1);
    check("t4 level", 160'(level_o), 160'(16));
    cyc(2'b11, 64'd19, 64'd20, 1'b1);
    check("t4 drop", 160'(drop_cnt_o), 160'(2));
    check("t4 level pop", 160'(level_o), 160'(15));
    cyc(2'b01, 64'd19, 64'd0, 1'b0);
    cyc(2'b01, 64'd20, 64'd0, 1'b0);
    check("t4 drop full", 160'(drop_cnt_o), 160'(3));
    for (int i = 0; i < 17; i++) cyc(2'b00, 64'd0, 64'd0, 1'b1);

    // Order wrap on the 3-bit-order instance.
    do_reset();
    scyc(2'b11, 3'd0, 3'd1);
    check("w level", 160'(s_level), 160'(2));
    scyc(2'b11, 3'd2, 3'd3);
    scyc(2'b11, 3'd4, 3'd5);
    scyc(2'b11, 3'd6, 3'd7);
    scyc(2'b01, 3'd0, 3'd0);
    check("w err wrap", 160'(s_err), 160'(0));
    check("w ovf", 160'(s_ovf), 160'(0));
    check("w level5", 160'(s_level), 160'(5));
    scyc(2'b01, 3'd5, 3'd0);
    check("w err jump", 160'(s_err), 160'(1));
    scyc(2'b00, 3'd0, 3'd0);

    // Asynchronous reset mid-stream.
    do_reset();
    cyc(2'b11, 64'd0, 64'd1, 1'b0);
    cyc(2'b11, 64'd2, 64'd3, 1'b0);
    cyc(2'b11, 64'd4, 64'd5, 1'b0);
    cyc(2'b01, 64'd9, 64'd0, 1'b0);
    check("ar level7", 160'(level_o), 160'(7));
    check("ar err set", 160'(order_err_o), 160'(1));
    chk_en = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check("ar valid", 160'(trace_valid_o), 160'(0));
    check("ar level", 160'(level_o), 160'(0));
    check("ar flags", 160'({overflow_o, order_err_o}), 160'(0));
    model_clear();
    valid = '0;
    @(negedge clk_i); rst_ni = 1'b1; chk_en = 1'b1;
    cyc(2'b01, 64'd0, 64'd0, 1'b1);
    cyc(2'b00, 64'd0, 64'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
